sccb_writer: RTL and testbench

SCCB_WRITER -- requirements
Module: sccb_writer

---
 rtl/sccb_pkg.sv | 17 +
 rtl/sccb_tick_gen.sv | 16 +
 rtl/sccb_writer.sv | 88 ++++++++
 tb/tb_sccb_writer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared state type, frame geometry and bus-drive decode for the SCCB writer.
package sccb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_STOP, S_GAP} state_t;
  localparam int SCCB_BITS = 27;
  localparam int START_Q = 2;
  localparam int STOP_Q = 2;
  localparam int GAP_Q = 4;
  function automatic logic ninth_bit(input logic [4:0] n);
    return n == 5'd8 || n == 5'd17 || n == 5'd26;
  endfunction
  // Returns {sioc, siod_oe} for a given position in the frame.
  function automatic logic [1:0] bus_drive(input state_t s, input logic [1:0] q, input logic ninth, input logic b);
    return s == S_START ? {q == 2'd0, 1'b1} :
           s == S_BITS  ? {q == 2'd1 || q == 2'd2, !ninth && !b} :
           s == S_STOP  ? {1'b1, q == 2'd0} : 2'b10;
  endfunction
endpackage

// File: rtl/sccb_tick_gen.sv
// sccb_tick_gen: quarter-bit strobe, held at phase 0 while not running.
module sccb_tick_gen #(
  parameter int QTR_CYCLES = 163
) (
  input  logic clk_in,
  input  logic rst_in_n,
  input  logic run_in,
  output logic tick_out
);
  localparam int W = QTR_CYCLES > 1 ? $clog2(QTR_CYCLES) : 1;
  logic [W-1:0] cnt_q;
  assign tick_out = run_in && cnt_q == W'(QTR_CYCLES - 1);
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) cnt_q <= '0;
    else cnt_q <= (!run_in || tick_out) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/sccb_writer.sv
// sccb_writer: SCCB 3-phase register write master (device, register, value).
module sccb_writer
  import sccb_pkg::*;
#(
  parameter int         QTR_CYCLES = 163,
  parameter logic [7:0] DEV_ADDR   = 8'h42
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       req_valid_in,
  input  logic [7:0] reg_addr_in,
  input  logic [7:0] reg_data_in,
  output logic       req_ready_out,
  output logic       sioc_out,
  output logic       siod_oe_out,
  input  logic       siod_in,
  output logic       done_out,
  output logic       nack_out
);
  state_t state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [4:0] bit_q, bit_d;
  logic [23:0] sreg_q, sreg_d;
  logic nack_d, sioc_d, oe_d, tick, accept, last_qtr, ninth, last_bit;
  sccb_tick_gen #(.QTR_CYCLES(QTR_CYCLES)) u_tick (
    .clk_in  (clk_in),
    .rst_in_n(rst_in_n),
    .run_in  (state_q != S_IDLE),
    .tick_out(tick)
  );
  always_comb begin
    accept = req_ready_out && req_valid_in;
    ninth = ninth_bit(bit_q);
    last_bit = bit_q == 5'(SCCB_BITS - 1);
    last_qtr = state_q == S_START ? qtr_q == 2'(START_Q - 1) :
               state_q == S_BITS  ? qtr_q == 2'd3 :
               state_q == S_STOP  ? qtr_q == 2'(STOP_Q - 1) :
               state_q == S_GAP   ? qtr_q == 2'(GAP_Q - 1) : 1'b0;
    state_d = state_q;
    qtr_d = qtr_q;
    bit_d = bit_q;
    sreg_d = sreg_q;
    nack_d = nack_out;
    if (accept) begin
      state_d = S_START;
      qtr_d = 2'd0;
      bit_d = 5'd0;
      sreg_d = {DEV_ADDR, reg_addr_in, reg_data_in};
      nack_d = 1'b0;
    end else if (tick) begin
      qtr_d = last_qtr ? 2'd0 : qtr_q + 2'd1;
      // Ninth bit is don't-care: a high sample only flags nack, the frame carries on.
      nack_d = nack_out || (state_q == S_BITS && ninth && qtr_q == 2'd2 && siod_in);
      if (state_q == S_BITS && qtr_q == 2'd3) begin
        sreg_d = ninth ? sreg_q : sreg_q << 1;
        bit_d = last_bit ? 5'd0 : bit_q + 5'd1;
      end
      if (last_qtr)
        state_d = state_q == S_START ? S_BITS :
                  state_q == S_BITS  ? (last_bit ? S_STOP : S_BITS) :
                  state_q == S_STOP  ? S_GAP : S_IDLE;
    end
    // Bus pins are decoded from the next state so they register in step with it.
    {sioc_d, oe_d} = bus_drive(state_d, qtr_d, ninth_bit(bit_d), sreg_d[23]);
  end
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      state_q <= S_IDLE;
      qtr_q <= 2'd0;
      bit_q <= 5'd0;
      sreg_q <= 24'd0;
      req_ready_out <= 1'b1;
      sioc_out <= 1'b1;
      siod_oe_out <= 1'b0;
      done_out <= 1'b0;
      nack_out <= 1'b0;
    end else begin
      state_q <= state_d;
      qtr_q <= qtr_d;
      bit_q <= bit_d;
      sreg_q <= sreg_d;
      req_ready_out <= state_d == S_IDLE;
      sioc_out <= sioc_d;
      siod_oe_out <= oe_d;
      done_out <= tick && state_q == S_STOP && last_qtr;
      nack_out <= nack_d;
    end
endmodule

// File: tb/tb_sccb_writer.sv
// tb_sccb_writer: timeline model of the SCCB frame, open-drain bus with ack responder and decoder.
module tb_sccb_writer;
  localparam int Q = 4;
  localparam int TOT = 116 * Q;
  localparam int DONE_J = 112 * Q;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
  logic [7:0] addr = 8'h00, data = 8'h00;
  logic ready, sioc, oe, done, nack, siod_line;
  logic ack_low = 1'b0;
  logic [2:0] ack_cfg = 3'b111;
  int checks = 0, errors = 0;
  assign siod_line = !(oe || ack_low);
  always #5 clk = ~clk;
  sccb_writer #(.QTR_CYCLES(Q), .DEV_ADDR(8'h42)) dut (
    .clk_in(clk), .rst_in_n(rst_n), .req_valid_in(valid), .reg_addr_in(addr), .reg_data_in(data),
    .req_ready_out(ready), .sioc_out(sioc), .siod_oe_out(oe), .siod_in(siod_line),
    .done_out(done), .nack_out(nack)
  );
  task automatic chk(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, expv);
    end
  endtask
  task automatic chk_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
    end
  endtask
  // Model: j counts cycles since the accept edge; the frame is a fixed quarter timeline.
  bit m_busy = 1'b0;
  int m_j = 0, m_acc = 0;
  logic [23:0] m_frame = 24'd0;
  logic [2:0] m_ack = 3'b111;
  logic m_nack = 1'b0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0;
      m_nack = 1'b0;
    end else if (!m_busy && valid) begin
      m_busy = 1'b1;
      m_j = 0;
      m_frame = {8'h42, addr, data};
      m_ack = ack_cfg;
      m_nack = 1'b0;
      m_acc++;
    end else if (m_busy) begin
      m_j++;
      if (m_j >= 37 * Q && m_j <= 109 * Q && (m_j - 37 * Q) % (36 * Q) == 0 && !m_ack[(m_j - 37 * Q) / (36 * Q)])
        m_nack = 1'b1;
      if (m_j == TOT) m_busy = 1'b0;
    end
  end
  function automatic logic [1:0] exp_bus(input int j);
    int n, b, qq;
    n = j / Q;
    if (n < 2) return {n == 0, 1'b1};
    if (n < 110) begin
      b = (n - 2) / 4;
      qq = (n - 2) % 4;
      return {qq == 1 || qq == 2, b % 9 != 8 && !m_frame[23 - (b / 9) * 8 - b % 9]};
    end
    if (n < 112) return {1'b1, n == 110};
    return 2'b10;
  endfunction
  initial forever begin
    logic [1:0] e;
    @(negedge clk);
    e = m_busy ? exp_bus(m_j) : 2'b10;
    chk("sioc", sioc, e[1]);
    chk("siod_oe", oe, e[0]);
    chk("ready", ready, !m_busy);
    chk("done", done, m_busy && m_j == DONE_J);
    chk("nack", nack, m_nack);
  end
  // Bus decoder, ack responder and protocol checker.
  logic [26:0] bits = '0;
  logic [23:0] last_frame = '0;
  int rise_n = 0, frames = 0, gap = 0;
  bit in_frame = 1'b0, gap_run = 1'b0;
  logic p_sioc = 1'b1, p_siod = 1'b1, p_oe = 1'b0;
  initial forever begin
    @(negedge clk);
    if (done) begin gap = 1; gap_run = 1'b1; end
    else if (gap_run && sioc && !oe && !ready) gap++;
    else gap_run = 1'b0;
    if (!rst_n) begin
      in_frame = 1'b0; rise_n = 0; ack_low = 1'b0;
      p_sioc = 1'b1; p_siod = 1'b1; p_oe = 1'b0;
    end else begin
      if (p_sioc && sioc && p_oe != oe)
        chk("siod_change_scl_high", (oe && !in_frame) || (!oe && in_frame && rise_n == 28), 1'b1);
      if (p_sioc && sioc && p_siod && !siod_line) begin
        in_frame = 1'b1; rise_n = 0; bits = '0;
      end else if (in_frame && p_sioc && sioc && !p_siod && siod_line) begin
        in_frame = 1'b0;
        frames++;
        last_frame = {bits[26:19], bits[17:10], bits[8:1]};
        chk_int("stop_rise_count", rise_n, 28);
        chk_int("decoded_frame", int'(last_frame), int'(m_frame));
      end else if (in_frame && !p_sioc && sioc) begin
        if (rise_n < 27) bits = {bits[25:0], siod_line};
        rise_n++;
      end
      if (!sioc) ack_low = in_frame && rise_n % 9 == 8 && rise_n < 27 && m_ack[rise_n / 9];
      p_sioc = sioc; p_siod = siod_line; p_oe = oe;
    end
  end
  task automatic wait_accept(output int k);
    int n0;
    n0 = m_acc;
    k = 0;
    while (m_acc == n0 && k < 2000) begin @(negedge clk); k++; end
    chk_int("accept_seen", int'(m_acc != n0), 1);
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] d, input logic [2:0] ack);
    int k;
    @(negedge clk);
    addr = a; data = d; ack_cfg = ack; valid = 1'b1;
    wait_accept(k);
    valid = 1'b0; addr = 8'($urandom); data = 8'($urandom);
  endtask
  task automatic wait_done_ready(output int td, output int tr);
    td = -1; tr = -1;
    for (int k = 1; k <= TOT + 50; k++) begin
      @(negedge clk);
      if (done && td < 0) td = k;
      if (ready) begin tr = k; break; end
    end
  endtask
  task automatic wait_idle();
    int k;
    k = 0;
    while (m_busy && k < TOT + 100) begin @(negedge clk); k++; end
    chk_int("idle_reached", int'(m_busy), 0);
    @(negedge clk);
  endtask
  initial begin
    int td, tr, k, f0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_sioc", sioc, 1'b1);
    chk("rst_oe", oe, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_nack", nack, 1'b0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h12, 8'h80, 3'b111);
    wait_done_ready(td, tr);
    chk_int("done_cycle", td, 448);
    chk_int("ready_cycle", tr, 464);
    chk("ack_nack", nack, 1'b0);
    chk_int("frame_12_80", int'(last_frame), 24'h421280);
    wait_idle();
    f0 = frames;
    send(8'h12, 8'h80, 3'b000);
    repeat (140) @(negedge clk);
    chk("silent_nack_early", nack, 1'b0);
    repeat (12) @(negedge clk);
    chk("silent_nack_late", nack, 1'b1);
    wait_done_ready(td, tr);
    chk_int("silent_done", td, 448 - 152);
    chk("silent_nack_end", nack, 1'b1);
    chk_int("silent_frames", frames, f0 + 1);
    chk_int("silent_frame", int'(last_frame), 24'h421280);
    @(negedge clk);
    addr = 8'hA5; data = 8'h3C; ack_cfg = 3'b111; valid = 1'b1;
    wait_accept(k);
    addr = 8'h5A; data = 8'hC3;
    wait_accept(k);
    chk_int("b2b_accept_interval", k, TOT + 1);
    chk_int("b2b_idle_gap", gap, 16);
    chk_int("b2b_first_frame", int'(last_frame), 24'h42A53C);
    valid = 1'b0;
    wait_idle();
    chk_int("b2b_second_frame", int'(last_frame), 24'h425AC3);
    f0 = frames;
    send(8'h77, 8'h11, 3'b111);
    repeat (217) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_sioc", sioc, 1'b1);
    chk("abort_oe", oe, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (500) @(negedge clk);
    chk_int("abort_no_frame", frames, f0);
    send(8'h0E, 8'hD7, 3'b111);
    wait_idle();
    chk_int("post_abort_frame", int'(last_frame), 24'h420ED7);
    @(negedge clk);
    addr = 8'h3A; data = 8'h5C; valid = 1'b1;
    wait_accept(k);
    valid = 1'b0; addr = 8'hFF; data = 8'hFF;
    wait_idle();
    chk_int("ff_after_accept", int'(last_frame), 24'h423A5C);
    for (int t = 0; t < 8; t++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send(8'($urandom), 8'($urandom), 3'($urandom));
      for (int j = 1; j < TOT - 8; j++) begin
        @(negedge clk);
        valid = 1'($urandom); addr = 8'($urandom); data = 8'($urandom);
      end
      valid = 1'b0;
      wait_idle();
    end
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
